// File: rtl/axi_sd_pkg.sv
// Shared definitions for the axi_sd AXI4-Lite register slave:
// response codes, FSM state encodings and the register index decode.
package axi_sd_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,  // nothing held
        W_ADDR = 2'd1,  // AW held, waiting for W
        W_DATA = 2'd2,  // W held, waiting for AW
        W_RESP = 2'd3   // BVALID high
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    // Word index of a byte address; num_regs is a power of two, so the
    // upper address bits simply wrap (aliasing).
    function automatic int unsigned reg_index(input logic [31:0] addr,
                                              input int unsigned num_regs);
        return (addr >> 2) & (num_regs - 1);
    endfunction

endpackage

// File: rtl/axi_sd_wstrb_merge.sv
// Byte-lane merge: each lane takes new data where its strobe is set,
// otherwise keeps the old register contents. Purely combinational.
module axi_sd_wstrb_merge
    import axi_sd_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_data,
    input  logic [DATA_W-1:0]   new_data,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged
);

    for (genvar b = 0; b < DATA_W/8; b++) begin : g_byte
        assign merged[8*b +: 8] = strb[b] ? new_data[8*b +: 8] : old_data[8*b +: 8];
    end

endmodule

// File: rtl/axi_sd_lite_slave.sv
// AXI4-Lite slave with a small word-addressed register file for the axi_sd
// core. One write and one read in flight at a time on independent channels.
// Optional macro AXI_SD_ADDR_ERR_EN: addresses with bits set above the index
// field are not decoded and answer SLVERR; otherwise they alias.
// NUM_REGS must be a power of two and at least 2.
module axi_sd_lite_slave
    import axi_sd_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_q,
    output logic [NUM_REGS-1:0]                      reg_wr_stb
);

    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    wr_state_e wr_state, wr_state_nx;
    rd_state_e rd_state, rd_state_nx;

    // High from the first edge that samples reset released; gates the READYs
    // so nothing is accepted while reset is in effect.
    logic rst_done;

    logic [ADDR_W-1:0]                aw_addr_q;
    logic [DATA_W-1:0]                w_data_q;
    logic [STRB_W-1:0]                w_strb_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
    logic [DATA_W-1:0]                rdata_q;
    logic [1:0]                       rresp_q;
    logic [1:0]                       bresp_q;

    logic                             aw_held, w_held;
    logic                             aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0]                c_addr;
    logic [DATA_W-1:0]                c_data, c_merged;
    logic [STRB_W-1:0]                c_strb;
    logic [IDX_W-1:0]                 c_idx, r_idx;
    logic                             c_err, r_err;

    // PROT carries no meaning for this register file.
    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Reset-release tracker
    always_ff @(posedge S_AXI_ACLK) begin
        rst_done <= S_AXI_ARESETN;
    end

    // Write FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) wr_state <= W_IDLE;
        else                wr_state <= wr_state_nx;
    end

    // Write FSM next state, handshakes and commit decision
    always_comb begin
        wr_state_nx   = wr_state;
        aw_held       = (wr_state == W_ADDR);
        w_held        = (wr_state == W_DATA);
        S_AXI_BVALID  = (wr_state == W_RESP);
        S_AXI_AWREADY = rst_done && ((wr_state == W_IDLE) || (wr_state == W_DATA));
        S_AXI_WREADY  = rst_done && ((wr_state == W_IDLE) || (wr_state == W_ADDR));
        aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs          = S_AXI_WVALID && S_AXI_WREADY;
        commit        = (aw_held || aw_hs) && (w_held || w_hs);
        case (wr_state)
            W_IDLE: begin
                if (commit)     wr_state_nx = W_RESP;
                else if (aw_hs) wr_state_nx = W_ADDR;
                else if (w_hs)  wr_state_nx = W_DATA;
            end
            W_ADDR, W_DATA: begin
                if (commit) wr_state_nx = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY) wr_state_nx = W_IDLE;
            end
            default: wr_state_nx = W_IDLE;
        endcase
    end

    // Holding registers for whichever of AW / W arrives first
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
        end
    end

    // Commit operands: held copy if already captured, else the live bus
    assign c_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign c_data = w_held  ? w_data_q  : S_AXI_WDATA;
    assign c_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;
    assign c_idx  = IDX_W'(reg_index(32'(c_addr), NUM_REGS));
    assign r_idx  = IDX_W'(reg_index(32'(S_AXI_ARADDR), NUM_REGS));

`ifdef AXI_SD_ADDR_ERR_EN
    // Any bit above the index field marks the access as undecoded.
    localparam logic [ADDR_W-1:0] HI_MASK = ~((ADDR_W)'((1 << (IDX_W + 2)) - 1));
    assign c_err = |(c_addr & HI_MASK);
    assign r_err = |(S_AXI_ARADDR & HI_MASK);
`else
    assign c_err = 1'b0;
    assign r_err = 1'b0;
`endif

    axi_sd_wstrb_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_data (regs[c_idx]),
        .new_data (c_data),
        .strb     (c_strb),
        .merged   (c_merged)
    );

    // Register file update, write strobe pulse and write response
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            regs       <= '0;
            reg_wr_stb <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            reg_wr_stb <= '0;
            if (commit) begin
                bresp_q <= c_err ? RESP_SLVERR : RESP_OKAY;
                if (!c_err) begin
                    regs[c_idx]       <= c_merged;
                    reg_wr_stb[c_idx] <= 1'b1;
                end
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) rd_state <= R_IDLE;
        else                rd_state <= rd_state_nx;
    end

    // Read FSM next state and handshake
    always_comb begin
        rd_state_nx   = rd_state;
        S_AXI_ARREADY = rst_done && (rd_state == R_IDLE);
        S_AXI_RVALID  = (rd_state == R_RESP);
        ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
        case (rd_state)
            R_IDLE:  if (ar_hs)        rd_state_nx = R_RESP;
            R_RESP:  if (S_AXI_RREADY) rd_state_nx = R_IDLE;
            default: rd_state_nx = R_IDLE;
        endcase
    end

    // Read capture sees the register file before a same-edge write lands,
    // so a colliding read returns the pre-write value.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= r_err ? '0 : regs[r_idx];
            rresp_q <= r_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;
    assign reg_q       = regs;

endmodule
